// File: rtl/SAVE_params.sv
// rtl/SAVE_params.sv - shared geometry, width and state constants for the correlation engine
package SAVE_params;
    localparam int H_RES   = 640;
    localparam int V_RES   = 480;
    localparam int T_W     = 16;
    localparam int T_H     = 16;
    localparam int PIX_W   = 8;
    localparam int COORD_W = 13;
    localparam int FADDR_W = 20;
    localparam int TADDR_W = 8;
    localparam int ACC_W   = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;
endpackage

// File: rtl/corr_addr_gen.sv
// rtl/corr_addr_gen.sv - window scan counters, frame/template address math and edge detection
module corr_addr_gen
    import SAVE_params::*;
(
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iLoad,
    input  logic               iStep,
    input  logic [COORD_W-1:0] iX,
    input  logic [COORD_W-1:0] iY,
    output logic [FADDR_W-1:0] oFrameAddr,
    output logic [TADDR_W-1:0] oTmplAddr,
    output logic               oOutside,
    output logic               oLast
);
    localparam int CW = COORD_W + 1;
    localparam logic [TADDR_W-1:0] TX_LAST = TADDR_W'(T_W - 1);
    localparam logic [TADDR_W-1:0] TY_LAST = TADDR_W'(T_H - 1);

    logic [COORD_W-1:0] xOrg;
    logic [COORD_W-1:0] yOrg;
    logic [TADDR_W-1:0] tx;
    logic [TADDR_W-1:0] ty;
    logic [CW-1:0]      col;
    logic [CW-1:0]      row;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            xOrg <= '0;
            yOrg <= '0;
            tx   <= '0;
            ty   <= '0;
        end else if (iLoad) begin
            xOrg <= iX;
            yOrg <= iY;
            tx   <= '0;
            ty   <= '0;
        end else if (iStep) begin
            if (tx == TX_LAST) begin
                tx <= '0;
                ty <= ty + 1'b1;
            end else begin
                tx <= tx + 1'b1;
            end
        end
    end

    // One extra bit on row/col so the edge compare sees origins near the 13-bit limit correctly
    assign col        = {1'b0, xOrg} + CW'(tx);
    assign row        = {1'b0, yOrg} + CW'(ty);
    assign oFrameAddr = FADDR_W'(row) * FADDR_W'(H_RES) + FADDR_W'(col);
    assign oTmplAddr  = ty * TADDR_W'(T_W) + tx;
    assign oOutside   = (col >= CW'(H_RES)) || (row >= CW'(V_RES));
    assign oLast      = (tx == TX_LAST) && (ty == TY_LAST);
endmodule

// File: rtl/corr_window_engine.sv
// rtl/corr_window_engine.sv - template-vs-frame window correlation: FSM and multiply-accumulate
module corr_window_engine
    import SAVE_params::*;
(
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iFrameDone,
    input  logic               iStart,
    input  logic [COORD_W-1:0] iX,
    input  logic [COORD_W-1:0] iY,
    output logic [FADDR_W-1:0] oFrameAddr,
    output logic [TADDR_W-1:0] oTmplAddr,
    input  logic [PIX_W-1:0]   iFramePix,
    input  logic [PIX_W-1:0]   iTmplPix,
    output logic               oBusy,
    output logic               oCorrFinished,
    output logic [ACC_W-1:0]   oCurrentCorr
);
    logic [1:0]           state;
    logic [ACC_W-1:0]     acc;
    logic                 pairValid;
    logic                 startOk;
    logic                 outside;
    logic                 lastIdx;
    logic [2*PIX_W-1:0]   prod;
    logic [ACC_W-1:0]     addend;

    assign startOk = (state == ST_IDLE) && iStart && iFrameDone;

    corr_addr_gen uAddrGen (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iLoad      (startOk),
        .iStep      (state == ST_RUN),
        .iX         (iX),
        .iY         (iY),
        .oFrameAddr (oFrameAddr),
        .oTmplAddr  (oTmplAddr),
        .oOutside   (outside),
        .oLast      (lastIdx)
    );

    // Read data arrives one cycle after its address, so the in-window flag is delayed to match
    assign prod   = iFramePix * iTmplPix;
    assign addend = pairValid ? ACC_W'(prod) : '0;
    assign oBusy  = (state != ST_IDLE);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state         <= ST_IDLE;
            acc           <= '0;
            pairValid     <= 1'b0;
            oCorrFinished <= 1'b0;
            oCurrentCorr  <= '0;
        end else begin
            oCorrFinished <= 1'b0;
            pairValid     <= (state == ST_RUN) && !outside;
            case (state)
                ST_IDLE: begin
                    if (startOk) begin
                        acc   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc <= acc + addend;
                    if (!iFrameDone) begin
                        state <= ST_IDLE;
                    end else if (lastIdx) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!iFrameDone) begin
                        state <= ST_IDLE;
                    end else begin
                        oCurrentCorr  <= acc + addend;
                        oCorrFinished <= 1'b1;
                        state         <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_corr_window_engine.sv
// tb/tb_corr_window_engine.sv - directed self-checking bench for corr_window_engine
module tb_corr_window_engine;
    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iFrameDone = 1'b1;
    logic        iStart = 1'b0;
    logic [12:0] iX = '0;
    logic [12:0] iY = '0;
    logic [19:0] oFrameAddr;
    logic [7:0]  oTmplAddr;
    logic [7:0]  iFramePix = '0;
    logic [7:0]  iTmplPix = '0;
    logic        oBusy;
    logic        oCorrFinished;
    logic [31:0] oCurrentCorr;

    int errCount = 0;
    int checkCount = 0;
    int fv = 0;
    int tv = 0;
    bit addrMode = 1'b0;

    corr_window_engine dut (
        .iCLK          (iCLK),
        .iRST          (iRST),
        .iFrameDone    (iFrameDone),
        .iStart        (iStart),
        .iX            (iX),
        .iY            (iY),
        .oFrameAddr    (oFrameAddr),
        .oTmplAddr     (oTmplAddr),
        .iFramePix     (iFramePix),
        .iTmplPix      (iTmplPix),
        .oBusy         (oBusy),
        .oCorrFinished (oCorrFinished),
        .oCurrentCorr  (oCurrentCorr)
    );

    always #10 iCLK = ~iCLK;

    // Synchronous-read memories: frame pixel is a constant or the low byte of its own address
    always @(posedge iCLK) begin
        iFramePix <= addrMode ? oFrameAddr[7:0] : 8'(fv);
        iTmplPix  <= 8'(tv);
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_busy"}, 32'(oBusy), 0);
        checkVal({tag, "_fin"}, 32'(oCorrFinished), 0);
        checkVal({tag, "_corr"}, oCurrentCorr, 0);
        checkVal({tag, "_faddr"}, 32'(oFrameAddr), 0);
        checkVal({tag, "_taddr"}, 32'(oTmplAddr), 0);
    endtask

    // Called at a falling edge; that cycle is cycle 0 of the run
    task automatic runCorr(input string tag, input int x, input int y, input int firstAddr,
                           input bit expectPulse, input int expectVal,
                           input int extraAt, input int dropAt);
        int pulses = 0;
        int pulseCyc = -1;
        logic [31:0] pulseVal = '0;
        iX = 13'(x);
        iY = 13'(y);
        iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        for (int c = 1; c <= 265; c++) begin
            if (c == 1) begin
                checkVal({tag, "_busy1"}, 32'(oBusy), 1);
                checkVal({tag, "_taddr1"}, 32'(oTmplAddr), 0);
                checkVal({tag, "_faddr1"}, 32'(oFrameAddr), 32'(firstAddr));
            end
            if (oCorrFinished) begin
                pulses++;
                pulseCyc = c;
                pulseVal = oCurrentCorr;
            end
            if (expectPulse && c == 258) checkVal({tag, "_busyDone"}, 32'(oBusy), 1);
            if (expectPulse && c == 259) checkVal({tag, "_busyIdle"}, 32'(oBusy), 0);
            if (dropAt > 0 && c == dropAt + 1) checkVal({tag, "_busyAbort"}, 32'(oBusy), 0);
            iStart = (c == extraAt);
            if (c == dropAt) iFrameDone = 1'b0;
            @(negedge iCLK);
        end
        iStart = 1'b0;
        iFrameDone = 1'b1;
        if (expectPulse) begin
            checkVal({tag, "_pulses"}, 32'(pulses), 1);
            checkVal({tag, "_pulseCyc"}, 32'(pulseCyc), 258);
            checkVal({tag, "_pulseVal"}, pulseVal, 32'(expectVal));
        end else begin
            checkVal({tag, "_pulses"}, 32'(pulses), 0);
        end
        checkVal({tag, "_corrHeld"}, oCurrentCorr, 32'(expectVal));
    endtask

    initial begin
        repeat (3) @(negedge iCLK);
        checkAllZero("rst");
        iRST = 1'b0;
        @(negedge iCLK);

        fv = 1; tv = 2;
        runCorr("basic", 0, 0, 0, 1'b1, 512, 0, 0);

        fv = 255; tv = 255;
        runCorr("max", 100, 50, 32100, 1'b1, 16646400, 0, 0);

        fv = 1; tv = 1;
        runCorr("rightEdge", 632, 0, 632, 1'b1, 128, 0, 0);
        runCorr("corner", 632, 472, 472 * 640 + 632, 1'b1, 64, 0, 0);

        addrMode = 1'b1; tv = 1;
        runCorr("pattern", 0, 0, 0, 1'b1, 18304, 0, 0);
        addrMode = 1'b0;

        iFrameDone = 1'b0;
        iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        @(negedge iCLK);
        checkVal("noFrameStart_busy", 32'(oBusy), 0);
        iFrameDone = 1'b1;
        @(negedge iCLK);

        fv = 1; tv = 2;
        runCorr("restart", 0, 0, 0, 1'b1, 512, 10, 0);

        fv = 1; tv = 1;
        runCorr("abort", 5, 5, 5 * 640 + 5, 1'b0, 512, 0, 100);

        fv = 3; tv = 3;
        iX = 13'd0;
        iY = 13'd0;
        iStart = 1'b1;
        @(negedge iCLK);
        iStart = 1'b0;
        repeat (49) @(negedge iCLK);
        iRST = 1'b1;
        #1;
        checkAllZero("midRst");
        @(negedge iCLK);
        iRST = 1'b0;
        fv = 1; tv = 2;
        runCorr("postRst", 0, 0, 0, 1'b1, 512, 0, 0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
